// File: rtl/beeb_bus_sequencer_pkg.sv
// Shared definitions for the Beeb bus sequencer: FSM state encodings,
// default timing parameters and a counter-width helper.
package beeb_bus_sequencer_pkg;

  localparam int DEFAULT_SYNC_STAGES = 2;
  localparam int DEFAULT_DOE_DELAY   = 2;
  localparam int DEFAULT_MAX_STRETCH = 15;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_PH1  = 3'd2,
    ST_PH2  = 3'd3,
    ST_DONE = 3'd4
  } bus_state_t;

  // Bits needed to count from 0 up to max_value inclusive (never less than 1).
  function automatic int cnt_width(input int max_value);
    return (max_value < 1) ? 1 : $clog2(max_value + 1);
  endfunction

endpackage

// File: rtl/beeb_bus_sequencer_phi_edge_detect.sv
// Synchroniser plus edge detector for an asynchronous Beeb-side signal.
// phi_s is the synchronised level; rise/fall are one-clock pulses that
// are high in the clock where phi_s has just changed.
module phi_edge_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset_n,
  input  logic phi_in,
  output logic phi_s,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   phi_d;

  // Shift the raw input through the synchroniser chain and keep a delayed copy for edge detection.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      phi_d  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], phi_in};
      phi_d  <= sync_q[SYNC_STAGES-1];
    end
  end

  assign phi_s = sync_q[SYNC_STAGES-1];
  assign rise  = phi_s & ~phi_d;
  assign fall  = ~phi_s & phi_d;

endmodule

// File: rtl/beeb_bus_sequencer.sv
// Runs one fast-side read or write onto the slow Beeb 6502 bus, aligned to
// Phi0. The request is latched, the cycle starts at a Phi0 fall, and the
// cycle repeats while Rdy is low, up to MAX_STRETCH repeats before an abort.
module beeb_bus_sequencer
  import beeb_bus_sequencer_pkg::*;
#(
  parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES,
  parameter int DOE_DELAY   = DEFAULT_DOE_DELAY,
  parameter int MAX_STRETCH = DEFAULT_MAX_STRETCH
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        phi_in,
  input  logic        rdy_in,
  input  logic        req,
  input  logic        req_we,
  input  logic [15:0] req_addr,
  input  logic [7:0]  req_wdata,
  output logic        ack,
  output logic        err,
  output logic [7:0]  rdata,
  output logic        busy,
  output logic [15:0] ext_addr,
  output logic        ext_rnw,
  output logic [7:0]  ext_dout,
  output logic        ext_doe,
  input  logic [7:0]  ext_din
);

  localparam int STRETCH_W = cnt_width(MAX_STRETCH);
  localparam int DOE_W     = cnt_width(DOE_DELAY);
  localparam logic [STRETCH_W-1:0] STRETCH_LIMIT = STRETCH_W'(MAX_STRETCH);
  localparam logic [DOE_W-1:0]     DOE_LIMIT     = DOE_W'(DOE_DELAY);

  bus_state_t state, state_next;

  logic phi_s, rise, fall, rdy_s;
  logic rdy_rise_unused, rdy_fall_unused;

  logic                 lat_we, lat_we_next;
  logic [15:0]          lat_addr, lat_addr_next;
  logic [7:0]           lat_wdata, lat_wdata_next;
  logic [STRETCH_W-1:0] stretch_cnt, stretch_cnt_next;
  logic [DOE_W-1:0]     doe_cnt, doe_cnt_next;
  logic                 doe_q, doe_next;
  logic                 ack_next, err_next, busy_next, ext_rnw_next;
  logic [7:0]           rdata_next, ext_dout_next;
  logic [15:0]          ext_addr_next;

  phi_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_phi_sync (
    .clock   (clock),
    .reset_n (reset_n),
    .phi_in  (phi_in),
    .phi_s   (phi_s),
    .rise    (rise),
    .fall    (fall)
  );

  phi_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_rdy_sync (
    .clock   (clock),
    .reset_n (reset_n),
    .phi_in  (rdy_in),
    .phi_s   (rdy_s),
    .rise    (rdy_rise_unused),
    .fall    (rdy_fall_unused)
  );

  // Gating with phi_s keeps the data drivers off during Phi0 low, including the fall clock itself.
  assign ext_doe = doe_q & phi_s;

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_next;
  end

  // Datapath and bus-facing registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      lat_we      <= 1'b0;
      lat_addr    <= 16'h0000;
      lat_wdata   <= 8'h00;
      stretch_cnt <= '0;
      doe_cnt     <= '0;
      doe_q       <= 1'b0;
      ack         <= 1'b0;
      err         <= 1'b0;
      rdata       <= 8'h00;
      busy        <= 1'b0;
      ext_addr    <= 16'h0000;
      ext_rnw     <= 1'b1;
      ext_dout    <= 8'h00;
    end else begin
      lat_we      <= lat_we_next;
      lat_addr    <= lat_addr_next;
      lat_wdata   <= lat_wdata_next;
      stretch_cnt <= stretch_cnt_next;
      doe_cnt     <= doe_cnt_next;
      doe_q       <= doe_next;
      ack         <= ack_next;
      err         <= err_next;
      rdata       <= rdata_next;
      busy        <= busy_next;
      ext_addr    <= ext_addr_next;
      ext_rnw     <= ext_rnw_next;
      ext_dout    <= ext_dout_next;
    end
  end

  // Next-state and next-register values; everything holds unless a state says otherwise.
  always_comb begin
    state_next       = state;
    lat_we_next      = lat_we;
    lat_addr_next    = lat_addr;
    lat_wdata_next   = lat_wdata;
    stretch_cnt_next = stretch_cnt;
    doe_cnt_next     = doe_cnt;
    doe_next         = doe_q;
    ack_next         = 1'b0;
    err_next         = 1'b0;
    rdata_next       = rdata;
    busy_next        = busy;
    ext_addr_next    = ext_addr;
    ext_rnw_next     = ext_rnw;
    ext_dout_next    = ext_dout;

    case (state)
      ST_IDLE: begin
        if (req && !ack) begin
          lat_we_next      = req_we;
          lat_addr_next    = req_addr;
          lat_wdata_next   = req_wdata;
          busy_next        = 1'b1;
          stretch_cnt_next = '0;
          state_next       = ST_WAIT;
        end
      end

      ST_WAIT: begin
        if (fall) begin
          ext_addr_next = lat_addr;
          ext_rnw_next  = ~lat_we;
          ext_dout_next = lat_wdata;
          state_next    = ST_PH1;
        end
      end

      ST_PH1: begin
        doe_next = 1'b0;
        if (rise) begin
          doe_cnt_next = '0;
          doe_next     = lat_we & (DOE_LIMIT == '0);
          state_next   = ST_PH2;
        end
      end

      ST_PH2: begin
        if (fall) begin
          doe_next = 1'b0;
          if (rdy_s) begin
            if (!lat_we) rdata_next = ext_din;
            ack_next     = 1'b1;
            ext_rnw_next = 1'b1;
            state_next   = ST_DONE;
          end else if (stretch_cnt < STRETCH_LIMIT) begin
            stretch_cnt_next = stretch_cnt + 1'b1;
            state_next       = ST_PH1;
          end else begin
            if (!lat_we) rdata_next = 8'hFF;
            err_next     = 1'b1;
            ack_next     = 1'b1;
            ext_rnw_next = 1'b1;
            state_next   = ST_DONE;
          end
        end else begin
          if (doe_cnt != DOE_LIMIT) doe_cnt_next = doe_cnt + 1'b1;
          doe_next = lat_we & (doe_cnt_next == DOE_LIMIT);
        end
      end

      ST_DONE: begin
        busy_next  = 1'b0;
        state_next = ST_IDLE;
      end

      default: state_next = ST_IDLE;
    endcase
  end

endmodule
